// File: rtl/ram_burst_pkg.sv
// Shared types for the RAM burst master: FSM state encoding and burst beat-count helper.
package ram_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        FILL  = 2'd3
    } state_e;

    // Number of words addressable with an addr_w-bit address (also the longest burst).
    function automatic int unsigned beat_count(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_rd_stage.sv
// One-entry registered read output: captures a RAM word on load and holds it until the consumer accepts.
module ram_rd_stage #(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [M-1:0] data_i,
    input  logic         rd_ready_i,
    output logic         rd_valid_o,
    output logic [M-1:0] rd_data_o
);

    logic         valid_q;
    logic [M-1:0] data_q;

    // Output register: load wins, otherwise an accepted beat empties the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= {M{1'b0}};
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (rd_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign rd_valid_o = valid_q;
    assign rd_data_o  = data_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port RAM: write bursts from the wr stream, read bursts to the rd stream.
// Optional constant-fill write bursts are enabled with the RAM_BURST_FILL_EN macro.
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int N = 6,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  logic [N-1:0] cmd_addr,
    input  logic [N-1:0] cmd_len,
`ifdef RAM_BURST_FILL_EN
    input  logic         cmd_fill,
    input  logic [M-1:0] cmd_fill_data,
`endif
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [M-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [M-1:0] rd_data,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [M-1:0] mem_wdata,
    input  logic [M-1:0] mem_rdata,
    output logic         busy,
    output logic         done
);

    state_e       state_q, state_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] rem_q, rem_d;
    logic         issued_q, issued_d;
    logic [N-1:0] addr_inc_s;
    logic         rd_load_s;
`ifdef RAM_BURST_FILL_EN
    logic [M-1:0] fill_q, fill_d;
`endif

    // Address advance wraps at the top of the RAM.
    assign addr_inc_s = N'((32'(addr_q) + 32'd1) % beat_count(N));

    // Next-state, RAM strobes and handshake decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        issued_d  = issued_q;
`ifdef RAM_BURST_FILL_EN
        fill_d    = fill_q;
`endif
        mem_we    = 1'b0;
        mem_wdata = wr_data;
        wr_ready  = 1'b0;
        rd_load_s = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    rem_d    = cmd_len;
                    issued_d = 1'b0;
                    if (cmd_write) begin
`ifdef RAM_BURST_FILL_EN
                        fill_d  = cmd_fill_data;
                        state_d = cmd_fill ? FILL : WRITE;
`else
                        state_d = WRITE;
`endif
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                mem_we   = wr_valid;
                if (wr_valid) begin
                    addr_d = addr_inc_s;
                    if (rem_q == {N{1'b0}}) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - N'(1);
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            READ: begin
                // issued_q marks that the final beat has already been captured.
                rd_load_s = !issued_q && (!rd_valid || rd_ready);
                if (rd_load_s) begin
                    addr_d = addr_inc_s;
                    if (rem_q == {N{1'b0}}) begin
                        issued_d = 1'b1;
                    end else begin
                        rem_d = rem_q - N'(1);
                    end
                end else begin
                    addr_d = addr_q;
                end
                if (rd_valid && rd_ready && issued_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                end
            end
`ifdef RAM_BURST_FILL_EN
            FILL: begin
                mem_we    = 1'b1;
                mem_wdata = fill_q;
                addr_d    = addr_inc_s;
                if (rem_q == {N{1'b0}}) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    rem_d = rem_q - N'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= {N{1'b0}};
            rem_q    <= {N{1'b0}};
            issued_q <= 1'b0;
`ifdef RAM_BURST_FILL_EN
            fill_q   <= {M{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            issued_q <= issued_d;
`ifdef RAM_BURST_FILL_EN
            fill_q   <= fill_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_addr  = addr_q;

    ram_rd_stage #(.M(M)) u_rd_stage (
        .clk        (clk),
        .reset      (reset),
        .load_i     (rd_load_s),
        .data_i     (mem_rdata),
        .rd_ready_i (rd_ready),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data)
    );

endmodule
